// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: datapath width, register address width
// and the writeback buffer entry.
package cpu_pkg;
  localparam int XLEN      = 32;
  localparam int REG_ADR_W = 5;

  typedef struct packed {
    logic [REG_ADR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer for the writeback stage; head is read from registered storage.
// WB_FORWARD_EN exposes the storage, read pointer and occupancy for forwarding lookups.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  wb_entry_t                  entry_i,
  input  logic                       pop_i,
  output wb_entry_t                  head_o,
  output logic                       empty_o,
  output logic                       full_o
`ifdef WB_FORWARD_EN
  , output wb_entry_t [DEPTH-1:0]    entries_o
  , output logic [$clog2(DEPTH)-1:0] rd_ptr_o
  , output logic [$clog2(DEPTH):0]   count_o
`endif
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end
  end

`ifdef WB_FORWARD_EN
  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;
`endif
endmodule

// File: rtl/writeback.sv
// Writeback stage: buffers ALU results toward the register manager, emits branch
// redirect pulses and counts retired writes. WB_FORWARD_EN adds a buffer forwarding lookup.
module writeback
  import cpu_pkg::*;
#(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid_i,
  output logic            alu_ok_o,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_branch_i,
  input  logic [XLEN-1:0] alu_target_i,
  output logic            res_v_o,
  output logic [4:0]      res_adr_o,
  output logic [XLEN-1:0] res_data_o,
  input  logic            res_ok_i,
  output logic            br_valid_o,
  output logic [XLEN-1:0] br_target_o,
  output logic [31:0]     wb_count_o
`ifdef WB_FORWARD_EN
  , input  logic [4:0]      fwd_adr_i
  , output logic            fwd_hit_o
  , output logic [XLEN-1:0] fwd_data_o
`endif
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t       head;
  wb_entry_t       new_entry;
  logic            empty, full;
  logic            xfer, push, pop;
  logic            br_valid_q, br_valid_d;
  logic [XLEN-1:0] br_target_q, br_target_d;
  logic [31:0]     wb_count_q, wb_count_d;

  assign alu_ok_o = ~full;
  assign xfer     = alu_valid_i & alu_ok_o;
  // x0 writes complete the handshake but are never queued
  assign push     = xfer & (alu_rd_i != '0);
  assign pop      = res_v_o & res_ok_i;

  assign new_entry = '{rd: alu_rd_i, data: alu_result_i};

`ifdef WB_FORWARD_EN
  wb_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           occ;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (new_entry),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (empty),
    .full_o  (full)
`ifdef WB_FORWARD_EN
    , .entries_o (entries)
    , .rd_ptr_o  (rd_ptr)
    , .count_o   (occ)
`endif
  );

  assign res_v_o    = ~empty;
  assign res_adr_o  = head.rd;
  assign res_data_o = head.data;

  always_comb begin
    br_valid_d  = xfer & alu_branch_i;
    br_target_d = br_target_q;
    wb_count_d  = wb_count_q;
    if (xfer & alu_branch_i) br_target_d = alu_target_i;
    if (pop)                 wb_count_d  = wb_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_valid_q  <= 1'b0;
      br_target_q <= '0;
      wb_count_q  <= '0;
    end else begin
      br_valid_q  <= br_valid_d;
      br_target_q <= br_target_d;
      wb_count_q  <= wb_count_d;
    end
  end

  assign br_valid_o  = br_valid_q;
  assign br_target_o = br_target_q;
  assign wb_count_o  = wb_count_q;

`ifdef WB_FORWARD_EN
  logic [PW-1:0] slot;

  // Walk oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    slot       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if (((PW+1)'(i) < occ) && (entries[slot].rd == fwd_adr_i) && (fwd_adr_i != '0)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = entries[slot].data;
      end
    end
  end
`endif
endmodule
